// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch stage: FSM encoding, instruction field
// positions and PC step.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Purely combinational split of an instruction word into decode fields;
// shared with the decoder stage.
module instr_field_split
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  assign opcode = instr[OPCODE_HI:OPCODE_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign funct  = instr[FUNCT_HI:FUNCT_LO];
  assign imm16  = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem req/ack, instruction register,
// stall hold and redirect with drain of an in-flight wrong-path fetch.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [5:0]        opcode_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [5:0]        funct_o,
  output logic [15:0]       imm16_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC) & ALIGN_MASK;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] saved_pc;
  logic [ADDR_W-1:0] redir_pc;

  assign redir_pc = redirect_pc_i & ALIGN_MASK;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      pc            <= PC_RST;
      saved_pc      <= '0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) pc <= redir_pc;
          state <= REQ;
        end
        REQ: begin
          if (imem_ack_i) begin
            if (redirect_i) begin
              pc <= redir_pc;
            end else begin
              instr_o       <= imem_rdata_i;
              instr_valid_o <= 1'b1;
              state         <= VALID;
            end
          end else if (redirect_i) begin
            // address must stay put until the in-flight ack returns
            saved_pc <= redir_pc;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            pc    <= redirect_i ? redir_pc : saved_pc;
            state <= REQ;
          end else if (redirect_i) begin
            saved_pc <= redir_pc;
          end
        end
        VALID: begin
          if (redirect_i) begin
            pc            <= redir_pc;
            instr_valid_o <= 1'b0;
            state         <= REQ;
          end else if (!stall_i) begin
            pc            <= pc + ADDR_W'(PC_STEP);
            instr_valid_o <= 1'b0;
            state         <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state == REQ) || (state == DRAIN);
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + ADDR_W'(PC_STEP);

  instr_field_split u_split (
    .instr  (instr_o),
    .opcode (opcode_o),
    .rs     (rs_o),
    .rt     (rt_o),
    .rd     (rd_o),
    .funct  (funct_o),
    .imm16  (imm16_o)
  );

endmodule
